// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// conversion FSM encoding and the BCD nibble-adjust helper.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } conv_state_e;

   localparam int BCD_ITER    = 14;
   localparam int MAX_DISPLAY = 9999;

   // Active-low segments, bit6..bit0 = G..A.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Double-dabble pre-shift correction: every nibble >= 5 gets +3.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int n = 0; n < 4; n++) begin
         if (bcd[4*n +: 4] >= 4'd5) res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational digit-to-segment decoder for the shared segment bus.
// Dash takes priority over blank; non-decimal codes show blank.
module seg_digit_decode
   import seg_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_BLANK;
      if (dash_i) begin
         seg_n_o = SEG_DASH;
      end else if (!blank_i) begin
         seg_n_o = seg_of_digit(digit_i);
      end
   end

endmodule

// File: rtl/seg_scan_controller.sv
// Captures a 32-bit value, converts it to 4 BCD digits by serial double-dabble
// and time-multiplexes the digits onto one common-anode segment bus.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [31:0]           value_in,
   input  logic                  load,
   output logic                  busy,
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic                  dp_n
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [3:0] ITER_LAST = 4'(BCD_ITER - 1);

   // Handshake: load is sampled only on an edge where busy is low; a load seen
   // while busy is high is dropped, never queued. busy is low exactly in IDLE.
   conv_state_e state_q, state_d;
   logic        busy_q, busy_d;
   logic [13:0] shift_q, shift_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  iter_q, iter_d;
   logic        ovf_q, ovf_d;
   logic [15:0] disp_bcd_q, disp_bcd_d;
   logic        disp_ovf_q, disp_ovf_d;
   logic        over_range;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [NUM_DIGITS-1:0] blank_vec;
   logic                  lead_run;
   logic [3:0]            digit_sel;
   logic                  cnt_wrap;

   assign over_range = (value_in > 32'(MAX_DISPLAY));

   // ---------------- conversion FSM: state register ----------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         shift_q    <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         ovf_q      <= 1'b0;
         disp_bcd_q <= '0;
         disp_ovf_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         ovf_q      <= ovf_d;
         disp_bcd_q <= disp_bcd_d;
         disp_ovf_q <= disp_ovf_d;
      end
   end

   // ---------------- conversion FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load) state_d = over_range ? ST_COMMIT : ST_CONVERT;
         end
         ST_CONVERT: begin
            if (iter_q == ITER_LAST) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- conversion FSM: datapath / outputs ----------------
   always_comb begin
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      ovf_d      = ovf_q;
      disp_bcd_d = disp_bcd_q;
      disp_ovf_d = disp_ovf_q;
      busy_d     = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               ovf_d   = over_range;
               shift_d = value_in[13:0];
               bcd_d   = '0;
               iter_d  = '0;
            end
         end
         ST_CONVERT: begin
            {bcd_d, shift_d} = {bcd_adjust(bcd_q), shift_q} << 1;
            iter_d           = iter_q + 4'd1;
         end
         ST_COMMIT: begin
            // All four digits and the overflow flag change on one edge.
            disp_bcd_d = ovf_q ? 16'd0 : bcd_q;
            disp_ovf_d = ovf_q;
         end
         default: ;
      endcase
   end

   // ---------------- leading-zero blanking ----------------
   always_comb begin
      lead_run  = 1'b1;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (disp_bcd_q[4*i +: 4] != 4'd0) lead_run = 1'b0;
         blank_vec[i] = BLANK_LEADING && lead_run;
      end
   end

   // ---------------- scan mux and refresh ----------------
   assign digit_sel = disp_bcd_q[{idx_q, 2'b00} +: 4];

   seg_digit_decode u_decode (
      .digit_i (digit_sel),
      .blank_i (blank_vec[idx_q]),
      .dash_i  (disp_ovf_q),
      .seg_n_o (seg_d)
   );

   assign cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

   always_comb begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      an_d = ~(NUM_DIGITS'(1) << idx_q);
   end

   // Segments and anode come from the same index on the same edge: no ghosting.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         idx_q <= '0;
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign busy  = busy_q;
   assign seg_n = seg_q;
   assign an_n  = an_q;
   assign dp_n  = 1'b1;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: two instances (leading blanking on and off)
// share stimulus; scan slots and busy pulses are checked against queued expectations.
module tb_seg_scan_controller;

  localparam int RDIV = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] value_in;
  logic        load;
  logic        busy_b, busy_z;
  logic [6:0]  seg_b, seg_z;
  logic [3:0]  an_b, an_z;
  logic        dp_b, dp_z;

  always #5 clock = ~clock;

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) dut_blank (
    .clock(clock), .resetn(resetn), .value_in(value_in), .load(load),
    .busy(busy_b), .seg_n(seg_b), .an_n(an_b), .dp_n(dp_b)
  );

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) dut_zero (
    .clock(clock), .resetn(resetn), .value_in(value_in), .load(load),
    .busy(busy_z), .seg_n(seg_z), .an_n(an_z), .dp_n(dp_z)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];   // {anode, seg with blanking, seg without blanking}
  int          busy_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] v, input int i, input bit blank);
    int unsigned p = 1;
    if (v > 32'd9999) return 7'b0111111;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blank && i > 0 && v < p) return 7'b1111111;
    return seg_of(int'((v / p) % 10));
  endfunction

  task automatic push_display(input logic [31:0] v);
    logic [3:0] an;
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
      exp_q.push_back({an, exp_seg(v, i, 1'b1), exp_seg(v, i, 1'b0)});
    end
  endtask

  // ---------------- monitor ----------------
  logic [3:0]  prev_an;
  int          slot_len;
  int          busy_len;
  logic [17:0] e;

  always @(negedge clock) begin
    if (!resetn) begin
      prev_an  = 4'hF;
      slot_len = 0;
      busy_len = 0;
    end else begin
      slot_len++;
      if (an_b !== prev_an) begin
        if (prev_an != 4'hF) begin
          check("slot_len", slot_len, RDIV);
          check("an_rotate", {28'd0, an_b}, {28'd0, prev_an[2:0], prev_an[3]});
        end
        check("an_align", {28'd0, an_z}, {28'd0, an_b});
        slot_len = 0;
        if (exp_q.size() > 0 && exp_q[0][17:14] == an_b) begin
          e = exp_q.pop_front();
          check("seg_blank", {25'd0, seg_b}, {25'd0, e[13:7]});
          check("seg_zero", {25'd0, seg_z}, {25'd0, e[6:0]});
        end
        prev_an = an_b;
      end
      if (busy_b) begin
        busy_len++;
      end else if (busy_len > 0) begin
        if (busy_exp_q.size() == 0) check("busy_unexpected", busy_len, 0);
        else check("busy_len", busy_len, busy_exp_q.pop_front());
        busy_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy_b && t < 40) begin
      tick();
      t++;
    end
    check(name, {31'd0, busy_b}, 0);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() > 0 && t < 60) begin
      tick();
      t++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_load(input logic [31:0] v, input int blen);
    value_in = v;
    load     = 1'b1;
    busy_exp_q.push_back(blen);
    tick();
    load = 1'b0;
    wait_idle("idle_timeout");
    tick();
    push_display(v);
    wait_drain("slots_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    load     = 1'b0;
    value_in = 32'd0;
    repeat (3) tick();
    check("rst_seg", {25'd0, seg_b}, 32'h7F);
    check("rst_an", {28'd0, an_b}, 32'hF);
    check("rst_busy", {31'd0, busy_b}, 0);
    check("rst_dp", {31'd0, dp_b}, 1);

    resetn = 1'b1;
    tick();
    check("rel_an", {28'd0, an_b}, 32'hE);
    check("rel_seg", {25'd0, seg_b}, 32'b1000000);
    check("rel_seg_zero", {25'd0, seg_z}, 32'b1000000);
    check("rel_dp", {31'd0, dp_z}, 1);
    push_display(32'd0);
    wait_drain("reset_slots");

    do_load(32'd7, 15);
    do_load(32'd1234, 15);
    do_load(32'd10000, 1);
    do_load(32'd9999, 15);
    do_load(32'd1005, 15);
    do_load(32'hFFFF_FFFF, 1);

    // load while converting is dropped
    value_in = 32'd5678;
    load     = 1'b1;
    busy_exp_q.push_back(15);
    tick();
    load = 1'b0;
    repeat (4) tick();
    value_in = 32'd42;
    load     = 1'b1;
    tick();
    load = 1'b0;
    wait_idle("drop_idle");
    tick();
    push_display(32'd5678);
    wait_drain("drop_slots");

    do_load(32'd42, 15);

    // load coinciding with the COMMIT edge is ignored
    value_in = 32'd2468;
    load     = 1'b1;
    busy_exp_q.push_back(15);
    tick();
    load = 1'b0;
    repeat (14) tick();
    check("busy_before_commit", {31'd0, busy_b}, 1);
    value_in = 32'd8;
    load     = 1'b1;
    tick();
    load = 1'b0;
    wait_idle("commit_idle");
    tick();
    push_display(32'd2468);
    wait_drain("commit_slots");

    // reset in the middle of a conversion
    value_in = 32'd9999;
    load     = 1'b1;
    tick();
    load = 1'b0;
    repeat (8) tick();
    resetn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_b}, 0);
    check("abort_busy_zero", {31'd0, busy_z}, 0);
    check("abort_an", {28'd0, an_b}, 32'hF);
    check("abort_seg", {25'd0, seg_b}, 32'h7F);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("abort_rel_seg", {25'd0, seg_b}, 32'b1000000);
    push_display(32'd0);
    wait_drain("abort_slots");
    do_load(32'd3, 15);

    repeat (4) tick();
    check("busy_pending", busy_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
